// File: rtl/modfs_serial.sv
// modfs_serial: limb-serial modular subtractor.
// dif = (op1 - op2 - bin) mod mod, computed one LIMB-wide slice per cycle:
// N cycles of subtract with a ripple borrow, then N cycles of a conditional
// add-back of the modulus.
// Optional feature macro: MODFS_FASTSKIP_EN. When defined, the add-back pass
// is skipped if the subtraction produced no final borrow (latency N or 2N).
// When undefined, the add-back always runs (constant latency 2N).
module modfs_serial #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned LIMB  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [WIDTH-1:0] mod,
    input  logic             bin,
    input  logic             en,
    output logic [WIDTH-1:0] dif,
    output logic             vld,
    output logic             busy
);

    localparam int unsigned N    = WIDTH / LIMB;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        ADD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;     // minuend, shifted right one limb per SUB cycle
    logic [WIDTH-1:0] b_sh;     // subtrahend, shifted alongside a_sh
    logic [WIDTH-1:0] m_sh;     // modulus, shifted right one limb per ADD cycle
    logic [WIDTH-1:0] r;        // partial result; new limbs enter at the top
    logic [CW-1:0]    cnt;      // limb index within the current pass
    logic             bc;       // borrow during SUB, carry during ADD
    logic             fb;       // final borrow of the SUB pass

    logic [LIMB:0]    sub_limb;
    logic [LIMB:0]    add_limb;
    logic [WIDTH-1:0] r_sub;
    logic [WIDTH-1:0] r_add;

    // Limb datapath: the low limb of each shift register is the one in flight.
    // Results rotate in from the top so that after N limbs r is in natural
    // order without any variable-index writes.
    always_comb begin
        sub_limb = {1'b0, a_sh[LIMB-1:0]} - {1'b0, b_sh[LIMB-1:0]}
                   - {{LIMB{1'b0}}, bc};
        add_limb = {1'b0, r[LIMB-1:0]}
                   + (fb ? {1'b0, m_sh[LIMB-1:0]} : '0)
                   + {{LIMB{1'b0}}, bc};
        r_sub    = (r >> LIMB) | (WIDTH'(sub_limb[LIMB-1:0]) << (WIDTH - LIMB));
        r_add    = (r >> LIMB) | (WIDTH'(add_limb[LIMB-1:0]) << (WIDTH - LIMB));
    end

    // Control FSM with registered dif/vld/busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            m_sh  <= '0;
            r     <= '0;
            cnt   <= '0;
            bc    <= 1'b0;
            fb    <= 1'b0;
            dif   <= '0;
            vld   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        a_sh  <= op1;
                        b_sh  <= op2;
                        m_sh  <= mod;
                        bc    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SUB;
                    end
                end
                SUB: begin
                    a_sh <= a_sh >> LIMB;
                    b_sh <= b_sh >> LIMB;
                    r    <= r_sub;
                    if (cnt == LAST) begin
                        fb  <= sub_limb[LIMB];
                        bc  <= 1'b0;
                        cnt <= '0;
`ifdef MODFS_FASTSKIP_EN
                        if (!sub_limb[LIMB]) begin
                            dif   <= r_sub;
                            vld   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= ADD;
                        end
`else
                        state <= ADD;
`endif
                    end else begin
                        bc  <= sub_limb[LIMB];
                        cnt <= cnt + CW'(1);
                    end
                end
                ADD: begin
                    m_sh <= m_sh >> LIMB;
                    r    <= r_add;
                    if (cnt == LAST) begin
                        // Final carry is dropped: the sum is exact mod 2^WIDTH.
                        dif   <= r_add;
                        vld   <= 1'b1;
                        busy  <= 1'b0;
                        bc    <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        bc  <= add_limb[LIMB];
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modfs_serial.sv
// Self-checking bench for modfs_serial: vector table, directed multi-cycle
// sequences and a random regression, with a scoreboard of expected results
// and expected vld cycles.
module tb_modfs_serial;

    localparam int unsigned WIDTH = 256;
    localparam int unsigned LIMB  = 32;
    localparam int unsigned N     = WIDTH / LIMB;

    localparam logic [255:0] P256 =
        256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] op1, op2, mod;
    logic             bin, en;
    logic [WIDTH-1:0] dif;
    logic             vld, busy;

    modfs_serial #(.WIDTH(WIDTH), .LIMB(LIMB)) dut (
        .clk (clk),
        .rst (rst),
        .op1 (op1),
        .op2 (op2),
        .mod (mod),
        .bin (bin),
        .en  (en),
        .dif (dif),
        .vld (vld),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned tests = 0;
    int unsigned fails = 0;

    typedef struct {
        logic [255:0] dif;
        int unsigned  at;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [255:0] op1;
        logic [255:0] op2;
        logic         bin;
        logic [255:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Scoreboard monitor: every vld must match the oldest pending expectation.
    always @(negedge clk) begin
        if (vld) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_vld: got vld=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dif", dif, e.dif);
                chk("vld_cycle", 256'(cyc), 256'(e.at));
            end
        end
    end

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
        return v;
    endfunction

    function automatic logic [255:0] ref_dif(input logic [255:0] a, input logic [255:0] b,
                                             input logic c, input logic [255:0] md);
        logic [256:0] d;
        d = {1'b0, a} - {1'b0, b} - {256'd0, c};
        return d[256] ? (d[255:0] + md) : d[255:0];
    endfunction

    // Drive a request at the current time (caller sits at a negedge); returns
    // the cycle number of the capture edge E, #1 after that edge.
    task automatic drive(input logic [255:0] a, input logic [255:0] b, input logic c,
                         input logic [255:0] md, input logic [255:0] want, input bit push,
                         output int unsigned e);
        int unsigned lat;
        op1 = a; op2 = b; bin = c; mod = md; en = 1'b1;
        e   = cyc + 1;
        lat = 2 * N;
`ifdef MODFS_FASTSKIP_EN
        if ({1'b0, a} >= ({1'b0, b} + {256'd0, c})) lat = N;
`endif
        if (push) sb.push_back('{want, e + lat});
        @(posedge clk);
        #1;
        en  = 1'b0;
        op1 = rand256(); op2 = rand256(); mod = rand256(); bin = 1'($urandom);
    endtask

    task automatic start(input logic [255:0] a, input logic [255:0] b, input logic c,
                         input logic [255:0] md, input logic [255:0] want, input bit push,
                         output int unsigned e);
        @(negedge clk);
        drive(a, b, c, md, want, push, e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 * N + 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t        vecs[8];
    int unsigned e, e2;

    initial begin
        rst = 1'b0; en = 1'b0; op1 = '0; op2 = '0; mod = P256; bin = 1'b0;

        vecs[0] = '{256'd10,          256'd3,        1'b0, 256'd7};
        vecs[1] = '{256'd3,           256'd10,       1'b0, P256 - 256'd7};
        vecs[2] = '{256'h1_0000_0000, 256'd0,        1'b1, 256'hFFFF_FFFF};
        vecs[3] = '{256'd5,           256'd5,        1'b1, P256 - 256'd1};
        vecs[4] = '{256'd0,           256'd0,        1'b0, 256'd0};
        vecs[5] = '{P256 - 256'd1,    256'd0,        1'b0, P256 - 256'd1};
        vecs[6] = '{256'd0,           P256 - 256'd1, 1'b1, 256'd0};
        vecs[7] = '{P256 - 256'd1,    P256 - 256'd1, 1'b1, P256 - 256'd1};

        repeat (3) @(negedge clk);
        chk("reset_dif", dif, 256'd0);
        chk("reset_vld", 256'(vld), 256'd0);
        chk("reset_busy", 256'(busy), 256'd0);
        rst = 1'b1;

        // Vector table.
        foreach (vecs[i]) begin
            start(vecs[i].op1, vecs[i].op2, vecs[i].bin, P256, vecs[i].exp, 1'b1, e);
            chk("busy_after_start", 256'(busy), 256'd1);
            wait_done();
        end

        // Busy rejection and back-to-back accept in the vld cycle.
        start(256'd3, 256'd10, 1'b0, P256, P256 - 256'd7, 1'b1, e);
        repeat (4) @(negedge clk);
        op1 = 256'd100; op2 = 256'd1; bin = 1'b0; mod = P256; en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (2 * N - 4) @(posedge clk);
        @(negedge clk);
        chk("b2b_vld_cycle_vld", 256'(vld), 256'd1);
        chk("b2b_vld_cycle_busy", 256'(busy), 256'd0);
        drive(256'd20, 256'd9, 1'b1, P256, 256'd10, 1'b1, e2);
        chk("b2b_spacing", 256'(e2 + 2 * N - (e + 2 * N)), 256'(2 * N + 1));
        wait_done();

        // Reset in the middle of an operation.
        start(256'd50, 256'd60, 1'b0, P256, 256'd0, 1'b0, e);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_dif", dif, 256'd0);
        chk("midrst_busy", 256'(busy), 256'd0);
        chk("midrst_vld", 256'(vld), 256'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2 * N + 4) @(negedge clk);
        chk("midrst_dif_after", dif, 256'd0);
        chk("midrst_busy_after", 256'(busy), 256'd0);
        start(256'd9, 256'd4, 1'b0, P256, 256'd5, 1'b1, e);
        wait_done();

        // Random regression over P-256 and random moduli.
        for (int i = 0; i < 2000; i++) begin
            logic [255:0] md, a, b;
            logic         c;
            md = (i % 2 == 0) ? P256 : (rand256() | 256'd1);
            a  = rand256() % md;
            b  = rand256() % md;
            c  = 1'($urandom);
            start(a, b, c, md, ref_dif(a, b, c, md), 1'b1, e);
            wait_done();
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
